axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
- Upstream AXI-Lite master stage that drives the team's AXI-Lite slave.
- Converts a simple single-command request/response interface (from a CPU stub, test sequencer or config engine) into one single-beat AXI-Lite write or read at a time.
- Returns response code, read data and measured transaction latency.
- Strictly one outstanding transaction. All AXI valids are held until their handshake completes, so it works with slaves whose READY is a registered pulse.

Parameters:
ADDR_WIDTH, 4, AXI address width and cmd_addr width
DATA_WIDTH, 32, AXI data width and cmd_wdata/rsp_rdata width
LAT_WIDTH, 16, width of saturating latency counter rsp_latency

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  target address
cmd_wdata  input  DATA_WIDTH  write data (ignored for reads)
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_write  output  1  echo of cmd_write for this response
rsp_resp  output  2  BRESP or RRESP captured
rsp_rdata  output  DATA_WIDTH  RDATA for reads, 0 for writes
rsp_latency  output  LAT_WIDTH  edges from cmd handshake to B/R capture, saturating
AWADDR, AWVALID (out), AWREADY (in): AXI-Lite write address channel
WDATA, WVALID (out), WREADY (in): AXI-Lite write data channel
BRESP[1:0], BVALID (in), BREADY (out): write response channel
ARADDR, ARVALID (out), ARREADY (in): read address channel
RDATA, RRESP[1:0], RVALID (in), RREADY (out): read data channel

Behaviour:
- Reset (async, immediate): state IDLE; cmd_ready=1; every AXI valid/ready output = 0; AWADDR, WDATA, ARADDR = 0; rsp_valid=0; rsp_write=0; rsp_resp=0; rsp_rdata=0; rsp_latency=0. Reset mid-transaction abandons it with no response.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP. All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake, latch addr/data/write and clear the latency counter to 0.
  - Write: go to WR_REQ with AWVALID=1, WVALID=1 from the next cycle.
  - Read: go to RD_REQ with ARVALID=1 from the next cycle.
- cmd_ready=0 in every state except IDLE.
- WR_REQ:
  - AW and W are tracked independently with done flags.
  - AWVALID drops on the edge where AWVALID && AWREADY; WVALID likewise. Either order, or both on the same edge, is legal.
  - A VALID never deasserts before its handshake, and AWADDR/WDATA remain stable while it is high.
  - When both are done (including the same edge as the last handshake), go to WR_RESP with BREADY=1.
- WR_RESP: on BVALID && BREADY, capture BRESP, set rsp_rdata=0, clear BREADY, go to RSP.
- RD_REQ: ARVALID held until ARVALID && ARREADY. On that edge clear ARVALID, set RREADY=1, go to RD_RESP.
- RD_RESP: on RVALID && RREADY, capture RDATA/RRESP, clear RREADY, go to RSP.
- BREADY/RREADY are 0 outside WR_RESP/RD_RESP. A BVALID/RVALID seen in other states is ignored and not captured.
- Latency counter:
  - Increments every edge while in WR_REQ, WR_RESP, RD_REQ or RD_RESP, and counts the capture edge.
  - Saturates at 2^LAT_WIDTH-1 with no wrap.
  - Copied to rsp_latency on the capture edge.
- RSP: rsp_valid=1 and all rsp_* stable until rsp_ready. On the handshake edge, rsp_valid=0 and go to IDLE; cmd_ready=1 the following cycle (no same-cycle accept).
- Non-OKAY responses (SLVERR/DECERR) are passed through unchanged, with no retry.
- No timeout: a slave that never responds stalls the block until reset.

Test Plan:
- Write against the companion slave: cmd write addr=0x3 data=0xDEADBEEF, rsp_ready=1 -> AWVALID/WVALID each high exactly 2 cycles; rsp_valid with rsp_write=1, rsp_resp=0, rsp_rdata=0, rsp_latency=4.
- Read-back: cmd read addr=0x3 -> ARVALID high 2 cycles; rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_latency=3.
- Skewed handshakes, bench slave: WREADY on cycle 1 after request, AWREADY on cycle 5, BVALID 3 cycles later with BRESP=2'b10 -> WVALID drops after its handshake while AWVALID holds; BREADY asserted only after both handshakes; rsp_resp=2'b10.
- Response backpressure: rsp_ready=0 for 10 cycles during RSP with cmd_valid=1 -> rsp_* stable, cmd_ready=0 throughout; second command accepted only the cycle after the rsp handshake.
- Saturation, LAT_WIDTH=4: ARREADY withheld for 20 cycles -> rsp_latency=15.
- Reset mid-transaction: resetn low while in WR_REQ with AWVALID=1 -> all AXI valids/readies and rsp_valid=0 immediately, cmd_ready=1. After release, a new read completes normally.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: turns single request/response commands into one AXI-Lite write or read at a time
// and reports response code, read data and saturating latency.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [1:0]            rsp_resp,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [LAT_WIDTH-1:0]  rsp_latency,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
  state_t state_q, state_d;
  logic cmd_ready_q, cmd_ready_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, rsp_valid_q, rsp_valid_d, write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] resp_q, resp_d;
  logic [LAT_WIDTH-1:0] lat_q, lat_d, rsp_lat_q, rsp_lat_d, lat_inc;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      lat_q       <= '0;
      rsp_lat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      lat_q       <= lat_d;
      rsp_lat_q   <= rsp_lat_d;
    end
  end
  // latency value that counts the current edge, pinned at all-ones
  assign lat_inc = (&lat_q) ? lat_q : lat_q + 1'b1;
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    lat_d       = lat_q;
    rsp_lat_d   = rsp_lat_q;
    unique case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        state_d     = cmd_write ? WR_REQ : RD_REQ;
        cmd_ready_d = 1'b0;
        awvalid_d   = cmd_write;
        wvalid_d    = cmd_write;
        arvalid_d   = !cmd_write;
        write_d     = cmd_write;
        addr_d      = cmd_addr;
        wdata_d     = cmd_wdata;
        lat_d       = '0;
      end
      WR_REQ: begin
        lat_d     = lat_inc;
        awvalid_d = awvalid_q && !AWREADY;
        wvalid_d  = wvalid_q && !WREADY;
        // a dropped valid doubles as that channel's done flag
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        lat_d = lat_inc;
        if (BVALID && bready_q) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          resp_d      = BRESP;
          rdata_d     = '0;
          rsp_lat_d   = lat_inc;
          rsp_valid_d = 1'b1;
        end
      end
      RD_REQ: begin
        lat_d = lat_inc;
        if (ARREADY) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        lat_d = lat_inc;
        if (RVALID && rready_q) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          resp_d      = RRESP;
          rdata_d     = RDATA;
          rsp_lat_d   = lat_inc;
          rsp_valid_d = 1'b1;
        end
      end
      RSP: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = write_q;
  assign rsp_resp    = resp_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_latency = rsp_lat_q;
  assign AWADDR      = addr_q;
  assign ARADDR      = addr_q;
  assign AWVALID     = awvalid_q;
  assign WDATA       = wdata_q;
  assign WVALID      = wvalid_q;
  assign BREADY      = bready_q;
  assign ARVALID     = arvalid_q;
  assign RREADY      = rready_q;
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: directed checks of the command master against a delay-programmable AXI-Lite slave model.
module tb_axi_lite_cmd_master;
  logic clk = 0, resetn = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0, rsp_valid, rsp_ready = 0, rsp_write;
  logic [3:0] cmd_addr = 0, AWADDR, ARADDR, rsp_latency;
  logic [31:0] cmd_wdata = 0, rsp_rdata, WDATA, RDATA;
  logic [1:0] rsp_resp, BRESP, RRESP;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  int checks = 0, failures = 0;
  int aw_n = 0, w_n = 0, ar_n = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0;
  logic [1:0] b_resp = 0;
  always #5 clk = ~clk;
  axi_lite_cmd_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LAT_WIDTH(4)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .rsp_latency(rsp_latency),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA), .WVALID(WVALID),
    .WREADY(WREADY), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY), .ARADDR(ARADDR),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY));
  // slave model: READY is a registered pulse raised after *_dly wait cycles
  logic [31:0] mem [16];
  int aw_c, w_c, b_c, ar_c;
  logic aw_got, w_got;
  logic [3:0] aw_a;
  logic [31:0] w_d;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      AWREADY <= 0; WREADY <= 0; BVALID <= 0; BRESP <= 0; ARREADY <= 0; RVALID <= 0; RDATA <= 0; RRESP <= 0;
      aw_c <= 0; w_c <= 0; b_c <= 0; ar_c <= 0; aw_got <= 0; w_got <= 0; aw_a <= 0; w_d <= 0;
    end else begin
      if (AWVALID && AWREADY) begin AWREADY <= 0; aw_got <= 1; aw_c <= 0; aw_a <= AWADDR; end
      else if (AWVALID && !aw_got) begin if (aw_c == aw_dly) AWREADY <= 1; else aw_c <= aw_c + 1; end
      if (WVALID && WREADY) begin WREADY <= 0; w_got <= 1; w_c <= 0; w_d <= WDATA; end
      else if (WVALID && !w_got) begin if (w_c == w_dly) WREADY <= 1; else w_c <= w_c + 1; end
      if (BVALID && BREADY) begin BVALID <= 0; aw_got <= 0; w_got <= 0; b_c <= 0; end
      else if (aw_got && w_got && !BVALID) begin
        if (b_c == b_dly) begin BVALID <= 1; BRESP <= b_resp; mem[aw_a] <= w_d; end
        else b_c <= b_c + 1;
      end
      if (RVALID && RREADY) RVALID <= 0;
      if (ARVALID && ARREADY) begin ARREADY <= 0; ar_c <= 0; RVALID <= 1; RDATA <= mem[ARADDR]; RRESP <= 0; end
      else if (ARVALID) begin if (ar_c == ar_dly) ARREADY <= 1; else ar_c <= ar_c + 1; end
    end
  end
  always @(negedge clk) begin
    if (AWVALID) aw_n++;
    if (WVALID) w_n++;
    if (ARVALID) ar_n++;
  end
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic send(logic w, logic [3:0] a, logic [31:0] d);
    int n = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) chk("cmd_ready_timeout", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic get_rsp(string tag, logic w, logic [1:0] r, logic [31:0] d, logic [3:0] l);
    int n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_write"}, rsp_write, w);
    chk({tag, "_resp"}, rsp_resp, r);
    chk({tag, "_rdata"}, rsp_rdata, d);
    chk({tag, "_lat"}, rsp_latency, l);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk({tag, "_rsp_drop"}, rsp_valid, 0);
  endtask
  initial begin
    int s0, s1, s2, n;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 0);
    chk("rst_rsp", {rsp_write, rsp_resp, rsp_rdata, rsp_latency}, 0);
    chk("rst_addr", {AWADDR, ARADDR, WDATA}, 0);
    resetn = 1;
    @(negedge clk);
    // companion-style write then read-back
    s0 = aw_n; s1 = w_n;
    send(1, 4'h3, 32'hDEADBEEF);
    get_rsp("wr", 1, 2'b00, 0, 4);
    chk("wr_aw_cycles", aw_n - s0, 2);
    chk("wr_w_cycles", w_n - s1, 2);
    s2 = ar_n;
    send(0, 4'h3, 0);
    get_rsp("rd", 0, 2'b00, 32'hDEADBEEF, 3);
    chk("rd_ar_cycles", ar_n - s2, 2);
    // skewed AW/W with SLVERR
    aw_dly = 4; b_dly = 3; b_resp = 2'b10;
    s0 = aw_n; s1 = w_n;
    send(1, 4'h5, 32'h12345678);
    @(negedge clk);
    @(negedge clk);
    chk("skew_w_dropped", WVALID, 0);
    chk("skew_aw_held", AWVALID, 1);
    n = 0;
    while (AWVALID && n < 20) begin chk("skew_bready_early", BREADY, 0); @(negedge clk); n++; end
    chk("skew_bready", BREADY, 1);
    get_rsp("skew", 1, 2'b10, 0, 11);
    chk("skew_aw_cycles", aw_n - s0, 6);
    chk("skew_w_cycles", w_n - s1, 2);
    aw_dly = 0; b_dly = 0; b_resp = 0;
    // response backpressure with a queued command
    send(0, 4'h5, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    cmd_write = 0; cmd_addr = 4'h3; cmd_valid = 1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 32'h12345678);
      chk("bp_lat", rsp_latency, 3);
      chk("bp_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("bp_rsp_done", rsp_valid, 0);
    chk("bp_cmd_ready_after", cmd_ready, 1);
    chk("bp_no_ar_yet", ARVALID, 0);
    @(negedge clk);
    cmd_valid = 0;
    chk("bp_accepted", cmd_ready, 0);
    chk("bp_arvalid", ARVALID, 1);
    get_rsp("bp2", 0, 2'b00, 32'hDEADBEEF, 3);
    // latency saturation
    ar_dly = 20;
    s2 = ar_n;
    send(0, 4'h3, 0);
    get_rsp("sat", 0, 2'b00, 32'hDEADBEEF, 15);
    chk("sat_ar_cycles", ar_n - s2, 22);
    ar_dly = 0;
    // reset in the middle of a write
    aw_dly = 10;
    send(1, 4'h7, 32'hCAFEF00D);
    @(negedge clk);
    chk("mid_awvalid", AWVALID, 1);
    resetn = 0;
    #1;
    chk("mid_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 0);
    chk("mid_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    resetn = 1;
    aw_dly = 0;
    @(negedge clk);
    send(0, 4'h3, 0);
    get_rsp("post", 0, 2'b00, 32'hDEADBEEF, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
